// File: rtl/fib_pkg.sv
// Shared widths and enums for the FIB lookup arbiter and its round-robin grant.
package fib_pkg;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_PIT  = 1'b0,
    REQ_DATA = 1'b1
  } req_id_t;

endpackage

// File: rtl/fib_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not granted last time wins.
module fib_rr_arbiter2
  import fib_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pit_valid,
  input  logic data_valid,
  output logic pit_grant,
  output logic data_grant
);

  req_id_t last_grant_reg;

  always_comb begin
    pit_grant  = 1'b0;
    data_grant = 1'b0;
    if (en) begin
      if (pit_valid && data_valid) begin
        pit_grant  = (last_grant_reg == REQ_DATA);
        data_grant = (last_grant_reg == REQ_PIT);
      end else begin
        pit_grant  = pit_valid;
        data_grant = data_valid;
      end
    end
  end

  // Starting from DATA lets PIT win the first tie after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= REQ_DATA;
    end else if (pit_grant) begin
      last_grant_reg <= REQ_PIT;
    end else if (data_grant) begin
      last_grant_reg <= REQ_DATA;
    end
  end

endmodule

// File: rtl/fib_lookup_arbiter.sv
// Shares one FIB longest-prefix-match engine between the PIT and data paths:
// one request in flight, one-cycle FIB strobe, bounded wait, tagged response.
module fib_lookup_arbiter
  import fib_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int PREFIX_W       = fib_pkg::PREFIX_W,
  parameter int LEN_W          = fib_pkg::LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pit_req_valid,
  input  logic [PREFIX_W-1:0] pit_req_prefix,
  input  logic [LEN_W-1:0]    pit_req_len,
  output logic                pit_req_ready,
  output logic                pit_resp_valid,
  input  logic                data_req_valid,
  input  logic [PREFIX_W-1:0] data_req_prefix,
  input  logic [LEN_W-1:0]    data_req_len,
  output logic                data_req_ready,
  output logic                data_resp_valid,
  output logic [PREFIX_W-1:0] resp_prefix,
  output logic [LEN_W-1:0]    resp_len,
  output logic                resp_err,
  output logic                fib_req,
  output logic [PREFIX_W-1:0] fib_prefix,
  output logic [LEN_W-1:0]    fib_len,
  input  logic                fib_done,
  input  logic [PREFIX_W-1:0] fib_match_prefix,
  input  logic [LEN_W-1:0]    fib_match_len,
  output logic                busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t          state_reg;
  req_id_t             owner_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [PREFIX_W-1:0] req_prefix_reg;
  logic [LEN_W-1:0]    req_len_reg;
  logic                fib_req_reg;
  logic                pit_resp_valid_reg;
  logic                data_resp_valid_reg;
  logic [PREFIX_W-1:0] resp_prefix_reg;
  logic [LEN_W-1:0]    resp_len_reg;
  logic                resp_err_reg;

  logic                pit_grant;
  logic                data_grant;
  logic [PREFIX_W-1:0] sel_prefix;
  logic [LEN_W-1:0]    sel_len;

  fib_rr_arbiter2 u_rr (
    .clk        (clk),
    .rst        (rst),
    .en         (state_reg == IDLE),
    .pit_valid  (pit_req_valid),
    .data_valid (data_req_valid),
    .pit_grant  (pit_grant),
    .data_grant (data_grant)
  );

  assign sel_prefix = pit_grant ? pit_req_prefix : data_req_prefix;
  assign sel_len    = pit_grant ? pit_req_len    : data_req_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= IDLE;
      owner_reg           <= REQ_PIT;
      cnt_reg             <= '0;
      req_prefix_reg      <= '0;
      req_len_reg         <= '0;
      fib_req_reg         <= 1'b0;
      pit_resp_valid_reg  <= 1'b0;
      data_resp_valid_reg <= 1'b0;
      resp_prefix_reg     <= '0;
      resp_len_reg        <= '0;
      resp_err_reg        <= 1'b0;
    end else begin
      fib_req_reg         <= 1'b0;
      pit_resp_valid_reg  <= 1'b0;
      data_resp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pit_grant || data_grant) begin
            owner_reg      <= pit_grant ? REQ_PIT : REQ_DATA;
            req_prefix_reg <= sel_prefix;
            req_len_reg    <= sel_len;
            // A zero-length prefix can never match; answer with an error at once.
            if (sel_len == '0) begin
              resp_prefix_reg     <= '0;
              resp_len_reg        <= '0;
              resp_err_reg        <= 1'b1;
              pit_resp_valid_reg  <= pit_grant;
              data_resp_valid_reg <= data_grant;
              state_reg           <= RESPOND;
            end else begin
              fib_req_reg <= 1'b1;
              state_reg   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          // fib_done takes priority over the timeout in the final cycle.
          if (fib_done) begin
            resp_prefix_reg     <= fib_match_prefix;
            resp_len_reg        <= fib_match_len;
            resp_err_reg        <= 1'b0;
            pit_resp_valid_reg  <= (owner_reg == REQ_PIT);
            data_resp_valid_reg <= (owner_reg == REQ_DATA);
            state_reg           <= RESPOND;
          end else if (cnt_reg == CNT_LAST) begin
            resp_prefix_reg     <= '0;
            resp_len_reg        <= '0;
            resp_err_reg        <= 1'b1;
            pit_resp_valid_reg  <= (owner_reg == REQ_PIT);
            data_resp_valid_reg <= (owner_reg == REQ_DATA);
            state_reg           <= RESPOND;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RESPOND: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign pit_req_ready   = pit_grant;
  assign data_req_ready  = data_grant;
  assign pit_resp_valid  = pit_resp_valid_reg;
  assign data_resp_valid = data_resp_valid_reg;
  assign resp_prefix     = resp_prefix_reg;
  assign resp_len        = resp_len_reg;
  assign resp_err        = resp_err_reg;
  assign fib_req         = fib_req_reg;
  assign fib_prefix      = req_prefix_reg;
  assign fib_len         = req_len_reg;
  assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_fib_lookup_arbiter.sv
// Scoreboard bench for fib_lookup_arbiter with a delay-programmable FIB model.
module tb_fib_lookup_arbiter;

  localparam int TO = 64;
  localparam int PW = 64;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pit_req_valid = 1'b0;
  logic [PW-1:0] pit_req_prefix = '0;
  logic [LW-1:0] pit_req_len = '0;
  logic          pit_req_ready;
  logic          pit_resp_valid;
  logic          data_req_valid = 1'b0;
  logic [PW-1:0] data_req_prefix = '0;
  logic [LW-1:0] data_req_len = '0;
  logic          data_req_ready;
  logic          data_resp_valid;
  logic [PW-1:0] resp_prefix;
  logic [LW-1:0] resp_len;
  logic          resp_err;
  logic          fib_req;
  logic [PW-1:0] fib_prefix;
  logic [LW-1:0] fib_len;
  logic          fib_done = 1'b0;
  logic [PW-1:0] fib_match_prefix = '0;
  logic [LW-1:0] fib_match_len = '0;
  logic          busy;

  fib_lookup_arbiter #(.TIMEOUT_CYCLES(TO), .PREFIX_W(PW), .LEN_W(LW)) dut (
    .clk              (clk),
    .rst              (rst),
    .pit_req_valid    (pit_req_valid),
    .pit_req_prefix   (pit_req_prefix),
    .pit_req_len      (pit_req_len),
    .pit_req_ready    (pit_req_ready),
    .pit_resp_valid   (pit_resp_valid),
    .data_req_valid   (data_req_valid),
    .data_req_prefix  (data_req_prefix),
    .data_req_len     (data_req_len),
    .data_req_ready   (data_req_ready),
    .data_resp_valid  (data_resp_valid),
    .resp_prefix      (resp_prefix),
    .resp_len         (resp_len),
    .resp_err         (resp_err),
    .fib_req          (fib_req),
    .fib_prefix       (fib_prefix),
    .fib_len          (fib_len),
    .fib_done         (fib_done),
    .fib_match_prefix (fib_match_prefix),
    .fib_match_len    (fib_match_len),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_pit;
    logic [PW-1:0] req_prefix;
    logic [LW-1:0] req_len;
    logic [PW-1:0] prefix;
    logic [LW-1:0] len;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  logic grant_q[$];
  exp_t e;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int fib_delay = 1;
  int fib_rem = 0;
  int last_ready_cyc = 0, last_fibreq_cyc = 0, last_done_cyc = 0, last_resp_cyc = 0;
  int fibreq_cnt = 0, resp_cnt = 0, data_resp_cnt = 0, pit_ready_cnt = 0;

  function automatic logic [LW-1:0] model_len(input logic [LW-1:0] l);
    return LW'((int'(l) * 2) / 3);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // FIB model: fib_delay=d answers d cycles after fib_req; 0 never answers.
  always @(posedge clk) begin
    #1;
    fib_done = 1'b0;
    fib_match_prefix = {$urandom, $urandom};
    fib_match_len = LW'($urandom);
    if (fib_req) begin
      fib_rem = fib_delay;
    end else if (fib_rem > 0) begin
      fib_rem--;
      if (fib_rem == 0) begin
        fib_done = 1'b1;
        fib_match_prefix = fib_prefix;
        fib_match_len = model_len(fib_len);
      end
    end
  end

  // Monitor: push expectations at grant, pop and compare at response.
  always @(negedge clk) begin
    if (!rst) begin
      if (pit_req_ready || data_req_ready) begin
        total_cnt++;
        if ((pit_req_ready && data_req_ready) || busy)
          $display("FAIL ready_exclusive: pit_ready=%b data_ready=%b busy=%b, required single ready while idle",
                   pit_req_ready, data_req_ready, busy);
        else
          pass_cnt++;
        e.is_pit = pit_req_ready;
        e.req_prefix = pit_req_ready ? pit_req_prefix : data_req_prefix;
        e.req_len = pit_req_ready ? pit_req_len : data_req_len;
        if (e.req_len == '0 || fib_delay == 0 || fib_delay > TO) begin
          e.prefix = '0; e.len = '0; e.err = 1'b1;
        end else begin
          e.prefix = e.req_prefix; e.len = model_len(e.req_len); e.err = 1'b0;
        end
        sb_q.push_back(e);
        grant_q.push_back(pit_req_ready);
        last_ready_cyc = cyc;
        if (pit_req_ready) pit_ready_cnt++;
        $display("grant %s prefix=%h len=%0d cyc=%0d", pit_req_ready ? "pit" : "data",
                 e.req_prefix, e.req_len, cyc);
      end
      if (fib_req) begin
        fibreq_cnt++;
        last_fibreq_cyc = cyc;
        if (sb_q.size() > 0) begin
          total_cnt++;
          if ({fib_prefix, fib_len} !== {sb_q[$].req_prefix, sb_q[$].req_len})
            $display("FAIL fib_args: got %h/%0d, required %h/%0d",
                     fib_prefix, fib_len, sb_q[$].req_prefix, sb_q[$].req_len);
          else
            pass_cnt++;
        end
      end
      if (fib_done) last_done_cyc = cyc;
      if (pit_resp_valid || data_resp_valid) begin
        resp_cnt++;
        last_resp_cyc = cyc;
        if (data_resp_valid) data_resp_cnt++;
        total_cnt++;
        if (sb_q.size() == 0) begin
          $display("FAIL unexpected_resp: pit=%b data=%b prefix=%h len=%0d err=%b, required no response",
                   pit_resp_valid, data_resp_valid, resp_prefix, resp_len, resp_err);
        end else begin
          e = sb_q.pop_front();
          $display("resp pit=%b data=%b prefix=%h len=%0d err=%b cyc=%0d",
                   pit_resp_valid, data_resp_valid, resp_prefix, resp_len, resp_err, cyc);
          if ({pit_resp_valid, data_resp_valid, resp_prefix, resp_len, resp_err} !==
              {e.is_pit, ~e.is_pit, e.prefix, e.len, e.err})
            $display("FAIL resp: got pit=%b data=%b %h/%0d err=%b, required pit=%b data=%b %h/%0d err=%b",
                     pit_resp_valid, data_resp_valid, resp_prefix, resp_len, resp_err,
                     e.is_pit, ~e.is_pit, e.prefix, e.len, e.err);
          else
            pass_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (pit_req_ready || data_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_resp(input int n0, input int k, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (resp_cnt >= n0 + k) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  // Single request on one side; valid drops right after the grant.
  task automatic one_req(input bit pit, input logic [PW-1:0] p, input logic [LW-1:0] l,
                         output bit ok);
    tick();
    if (pit) begin
      pit_req_valid = 1'b1; pit_req_prefix = p; pit_req_len = l;
    end else begin
      data_req_valid = 1'b1; data_req_prefix = p; data_req_len = l;
    end
    wait_ready(ok);
    tick();
    pit_req_valid = 1'b0;
    data_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({pit_req_ready, data_req_ready, pit_resp_valid, data_resp_valid, fib_req, busy,
         resp_err, resp_len, resp_prefix, fib_prefix, fib_len} !== '0)
      $display("FAIL reset_outputs: busy=%b fib_req=%b resp=%h/%0d err=%b, required all zero",
               busy, fib_req, resp_prefix, resp_len, resp_err);
    else
      pass_cnt++;
  endtask

  task automatic test_pit_only();
    bit ok;
    int f0, dr0, pr0, r0;
    fib_delay = 2;
    f0 = fibreq_cnt; dr0 = data_resp_cnt; pr0 = pit_ready_cnt; r0 = resp_cnt;
    one_req(1'b1, 64'h0000FFFF0000FFFF, 6'd48, ok);
    wait_resp(r0, 1, 100, ok);
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if (!ok) $display("FAIL pit_only_resp_timeout: got no response, required one"); else pass_cnt++;
    total_cnt++;
    if (pit_ready_cnt - pr0 != 1)
      $display("FAIL pit_only_ready_count: got %0d, required 1", pit_ready_cnt - pr0);
    else pass_cnt++;
    total_cnt++;
    if (fibreq_cnt - f0 != 1 || last_fibreq_cyc != last_ready_cyc + 1)
      $display("FAIL pit_only_fib_req: got %0d strobes at +%0d, required 1 at +1",
               fibreq_cnt - f0, last_fibreq_cyc - last_ready_cyc);
    else pass_cnt++;
    total_cnt++;
    if (last_resp_cyc != last_done_cyc + 1 || last_resp_cyc != last_fibreq_cyc + 3)
      $display("FAIL pit_only_latency: got resp-done=%0d resp-req=%0d, required 1 and 3",
               last_resp_cyc - last_done_cyc, last_resp_cyc - last_fibreq_cyc);
    else pass_cnt++;
    total_cnt++;
    if (data_resp_cnt != dr0)
      $display("FAIL pit_only_data_resp: got %0d data pulses, required 0", data_resp_cnt - dr0);
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    bit ok;
    int f0, r0;
    fib_delay = 1;
    f0 = fibreq_cnt; r0 = resp_cnt;
    one_req(1'b1, 64'h0000_0000_0000_DEAD, 6'd0, ok);
    wait_resp(r0, 1, 20, ok);
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if (!ok || last_resp_cyc != last_ready_cyc + 1)
      $display("FAIL zero_len_latency: got ok=%b resp-ready=%0d, required 1",
               ok, last_resp_cyc - last_ready_cyc);
    else pass_cnt++;
    total_cnt++;
    if (fibreq_cnt != f0)
      $display("FAIL zero_len_fib_req: got %0d strobes, required 0", fibreq_cnt - f0);
    else pass_cnt++;
  endtask

  task automatic test_timeout(input int delay, input bit pit, input logic [LW-1:0] l);
    bit ok;
    int r0;
    fib_delay = delay;
    r0 = resp_cnt;
    one_req(pit, 64'hABCD_0000_1234_0000 + PW'(delay), l, ok);
    wait_resp(r0, 1, TO + 20, ok);
    total_cnt++;
    if (!ok || last_resp_cyc != last_fibreq_cyc + TO + 1)
      $display("FAIL timeout_latency d=%0d: got ok=%b resp-req=%0d, required %0d",
               delay, ok, last_resp_cyc - last_fibreq_cyc, TO + 1);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL timeout_busy d=%0d: got %b after response, required 0", delay, busy);
    else pass_cnt++;
    wait_idle();
  endtask

  task automatic test_round_robin();
    bit ok;
    bit got;
    int r0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fib_delay = 1;
    grant_q.delete();
    r0 = resp_cnt;
    pit_req_valid = 1'b1; pit_req_prefix = 64'h1; pit_req_len = 6'd8;
    data_req_valid = 1'b1; data_req_prefix = 64'h2; data_req_len = 6'd16;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (grant_q.size() >= 4) begin
        got = 1'b1;
        break;
      end
    end
    tick();
    pit_req_valid = 1'b0;
    data_req_valid = 1'b0;
    wait_resp(r0, 4, 40, ok);
    total_cnt++;
    if (!got || !ok)
      $display("FAIL rr_progress: got grants=%0d resps=%0d, required 4 and 4",
               grant_q.size(), resp_cnt - r0);
    else pass_cnt++;
    for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
      total_cnt++;
      if (grant_q[i] !== ((i % 2) == 0))
        $display("FAIL rr_order[%0d]: got pit=%b, required pit=%b", i, grant_q[i], (i % 2) == 0);
      else pass_cnt++;
    end
    wait_idle();
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    int r0;
    fib_delay = 10;
    one_req(1'b1, 64'h5555_0000_0000_0000, 6'd24, ok);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({pit_req_ready, data_req_ready, pit_resp_valid, data_resp_valid, fib_req, busy,
         resp_err, resp_len, resp_prefix, fib_prefix, fib_len} !== '0)
      $display("FAIL wait_reset_outputs: busy=%b fib_req=%b resp=%h/%0d fib=%h, required all zero",
               busy, fib_req, resp_prefix, resp_len, fib_prefix);
    else pass_cnt++;
    sb_q.delete();
    r0 = resp_cnt;
    repeat (15) @(negedge clk);
    #1;
    total_cnt++;
    if (resp_cnt != r0)
      $display("FAIL wait_reset_stale_done: got %0d responses, required 0", resp_cnt - r0);
    else pass_cnt++;
    fib_delay = 1;
    grant_q.delete();
    tick();
    pit_req_valid = 1'b1; pit_req_prefix = 64'h7; pit_req_len = 6'd12;
    data_req_valid = 1'b1; data_req_prefix = 64'h8; data_req_len = 6'd12;
    wait_ready(ok);
    tick();
    pit_req_valid = 1'b0;
    data_req_valid = 1'b0;
    total_cnt++;
    if (!ok || grant_q.size() == 0 || grant_q[0] !== 1'b1)
      $display("FAIL wait_reset_first_grant: got ok=%b grants=%0d, required pit first",
               ok, grant_q.size());
    else pass_cnt++;
    wait_resp(r0, 1, 20, ok);
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_pit_only();
    wait_idle();
    test_zero_len();
    wait_idle();
    test_timeout(0, 1'b0, 6'd20);
    test_timeout(TO, 1'b1, 6'd40);
    test_timeout(TO + 1, 1'b0, 6'd33);
    test_round_robin();
    test_reset_in_wait();
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if (sb_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
